// File: rtl/perm_pkg.sv
// perm_pkg: shared definitions for the permutation sequencing controller.
//   - Index widths for the file and line counters.
//   - Default run dimensions.
//   - FSM state encoding.
package perm_pkg;

  localparam int FILE_IDX_W = 10;
  localparam int LINE_IDX_W = 6;

  localparam int DEF_NUM_FILES = 1;
  localparam int DEF_NUM_LINES = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/index_counter.sv
// index_counter: nested line/file counter for the permutation controller.
// Ports:
//   clk, rst   - rising-edge clock, synchronous active-high reset
//   clr        - return both indices to zero (priority over inc)
//   inc        - advance to the next line, rolling into the next file
//   line, file - current indices
//   last_line  - line is the final line of the current file
//   last       - line and file are both at their final values
// The counter saturates at the final line of the final file, so the
// indices keep their last values after a run.
module index_counter
  import perm_pkg::*;
#(
  parameter int NUM_FILES = DEF_NUM_FILES,
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [LINE_IDX_W-1:0] line,
  output logic [FILE_IDX_W-1:0] file,
  output logic                  last_line,
  output logic                  last
);

  localparam logic [LINE_IDX_W-1:0] LINE_MAX = LINE_IDX_W'(NUM_LINES - 1);
  localparam logic [FILE_IDX_W-1:0] FILE_MAX = FILE_IDX_W'(NUM_FILES - 1);

  logic [LINE_IDX_W-1:0] line_q, line_d;
  logic [FILE_IDX_W-1:0] file_q, file_d;
  logic                  last_file;

  assign last_line = (line_q == LINE_MAX);
  assign last_file = (file_q == FILE_MAX);
  assign last      = last_line && last_file;

  always_comb begin
    line_d = line_q;
    file_d = file_q;
    if (clr) begin
      line_d = '0;
      file_d = '0;
    end else if (inc && !last) begin
      if (!last_line) begin
        line_d = line_q + 1'b1;
      end else begin
        line_d = '0;
        file_d = file_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      file_q <= '0;
    end else begin
      line_q <= line_d;
      file_q <= file_d;
    end
  end

  assign line = line_q;
  assign file = file_q;

endmodule

// File: rtl/perm_controller.sv
// perm_controller: sequences the permutation datapath over every line of
// every file as READ -> LOAD -> WRITE, then pulses done.
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   start       - request a run (only honoured in IDLE)
//   busy        - high from the first READ cycle through the DONE cycle
//   done        - one-cycle completion pulse
//   read_file   - datapath read strobe (READ)
//   write_reg   - datapath register load (LOAD)
//   write_file  - datapath write strobe (WRITE)
//   file_index  - current file
//   line_index  - current line
// All outputs are registered; strobes are decoded from the next state so
// they line up exactly with the state register.
module perm_controller
  import perm_pkg::*;
#(
  parameter int NUM_FILES = DEF_NUM_FILES,
  parameter int NUM_LINES = DEF_NUM_LINES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  read_file,
  output logic                  write_reg,
  output logic                  write_file,
  output logic [FILE_IDX_W-1:0] file_index,
  output logic [LINE_IDX_W-1:0] line_index
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   read_file_q, read_file_d;
  logic   write_reg_q, write_reg_d;
  logic   write_file_q, write_file_d;

  logic   cnt_clr, cnt_inc;
  logic   last_line, last;

  // Indices clear when a run is accepted and advance at the end of each
  // WRITE, so they stay stable across the three phases of a line.
  assign cnt_clr = (state_q == S_IDLE) && start;
  assign cnt_inc = (state_q == S_WRITE);

  index_counter #(
    .NUM_FILES (NUM_FILES),
    .NUM_LINES (NUM_LINES)
  ) u_index_counter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .inc       (cnt_inc),
    .line      (line_index),
    .file      (file_index),
    .last_line (last_line),
    .last      (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = S_LOAD;
      S_LOAD:  state_d = S_WRITE;
      S_WRITE: begin
        if (!last_line)  state_d = S_READ;  // next line, same file
        else if (!last)  state_d = S_READ;  // first line of next file
        else             state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    read_file_d  = (state_d == S_READ);
    write_reg_d  = (state_d == S_LOAD);
    write_file_d = (state_d == S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      read_file_q  <= 1'b0;
      write_reg_q  <= 1'b0;
      write_file_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      read_file_q  <= read_file_d;
      write_reg_q  <= write_reg_d;
      write_file_q <= write_file_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign read_file  = read_file_q;
  assign write_reg  = write_reg_q;
  assign write_file = write_file_q;

endmodule

// File: tb/tb_perm_controller.sv
// tb_perm_controller: directed bench for perm_controller with two
// configurations (1 file x 4 lines, 3 files x 2 lines). Expected per-cycle
// output words are queued when a start is driven and popped every cycle.
module tb_perm_controller;

  localparam int FA = 1;
  localparam int LA = 4;
  localparam int FB = 3;
  localparam int LB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b;

  logic       busy_a, done_a, rd_a, wreg_a, wf_a;
  logic [9:0] fi_a;
  logic [5:0] li_a;
  logic       busy_b, done_b, rd_b, wreg_b, wf_b;
  logic [9:0] fi_b;
  logic [5:0] li_b;

  perm_controller #(.NUM_FILES(FA), .NUM_LINES(LA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .busy(busy_a), .done(done_a), .read_file(rd_a), .write_reg(wreg_a),
    .write_file(wf_a), .file_index(fi_a), .line_index(li_a)
  );

  perm_controller #(.NUM_FILES(FB), .NUM_LINES(LB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .busy(busy_b), .done(done_b), .read_file(rd_b), .write_reg(wreg_b),
    .write_file(wf_b), .file_index(fi_b), .line_index(li_b)
  );

  // {busy, done, read_file, write_reg, write_file, file[9:0], line[5:0]}
  logic [20:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, rd_a, wreg_a, wf_a, fi_a, li_a};
  assign obs_b = {busy_b, done_b, rd_b, wreg_b, wf_b, fi_b, li_b};

  logic [20:0] qa[$];
  logic [20:0] qb[$];
  logic [20:0] idle_a, idle_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  function automatic logic [20:0] mk(bit b, bit d, bit r, bit l, bit w,
                                     int f, int ln);
    return {b, d, r, l, w, 10'(f), 6'(ln)};
  endfunction

  // Queue the full expected output trace of one run, starting the cycle
  // after the start edge, and record the idle word that follows it.
  task automatic push_run(input int sel);
    int nf, nl;
    logic [20:0] v;
    nf = (sel == 0) ? FA : FB;
    nl = (sel == 0) ? LA : LB;
    for (int f = 0; f < nf; f++) begin
      for (int l = 0; l < nl; l++) begin
        for (int ph = 0; ph < 3; ph++) begin
          v = mk(1'b1, 1'b0, ph == 0, ph == 1, ph == 2, f, l);
          if (sel == 0) qa.push_back(v); else qb.push_back(v);
        end
      end
    end
    v = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, nf - 1, nl - 1);
    if (sel == 0) begin
      qa.push_back(v);
      idle_a = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nf - 1, nl - 1);
    end else begin
      qb.push_back(v);
      idle_b = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nf - 1, nl - 1);
    end
    $display("[TB] cycle %0d: run queued on dut_%s (%0d entries)", cyc,
             (sel == 0) ? "a" : "b", nf * nl * 3 + 1);
  endtask

  task automatic flush_reset();
    qa.delete();
    qb.delete();
    idle_a = '0;
    idle_b = '0;
  endtask

  // Advance one clock and compare both DUTs against the scoreboard.
  task automatic step();
    logic [20:0] exp_a, exp_b;
    @(posedge clk);
    #1;
    cyc++;
    exp_a = (qa.size() > 0) ? qa.pop_front() : idle_a;
    exp_b = (qb.size() > 0) ? qb.pop_front() : idle_b;
    n_tests++;
    assert (obs_a === exp_a) else begin
      n_fail++;
      $error("FAIL dut_a cycle %0d observed=%h expected=%h", cyc, obs_a, exp_a);
    end
    n_tests++;
    assert (obs_b === exp_b) else begin
      n_fail++;
      $error("FAIL dut_b cycle %0d observed=%h expected=%h", cyc, obs_b, exp_b);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    flush_reset();

    // Reset then idle.
    step();
    step();
    rst = 1'b0;
    repeat (10) step();

    // Single run on dut_a, with an ignored start at cycle 5 and another
    // in the DONE cycle, then a back-to-back start from IDLE.
    cyc = 0;
    start_a = 1'b1;
    push_run(0);
    step();                 // cycle 1: READ line 0
    start_a = 1'b0;
    repeat (4) step();      // cycle 5
    start_a = 1'b1;         // ignored while busy
    step();
    start_a = 1'b0;
    repeat (7) step();      // cycle 13: DONE
    start_a = 1'b1;         // ignored in DONE
    step();                 // cycle 14: IDLE
    push_run(0);            // start stays high: accepted from IDLE
    step();                 // cycle 15: READ of second run
    start_a = 1'b0;
    repeat (14) step();

    // Multi-file run on dut_b.
    cyc = 0;
    start_b = 1'b1;
    push_run(1);
    step();
    start_b = 1'b0;
    repeat (20) step();     // through done at cycle 19 and beyond

    // Reset mid-run on dut_a, then restart.
    cyc = 0;
    start_a = 1'b1;
    push_run(0);
    step();
    start_a = 1'b0;
    repeat (6) step();      // cycle 7
    rst = 1'b1;
    flush_reset();
    step();                 // cycle 8: IDLE, indices cleared, no done
    rst = 1'b0;
    step();
    step();                 // cycle 10
    start_a = 1'b1;
    push_run(0);
    step();                 // READ file 0 line 0
    start_a = 1'b0;
    repeat (14) step();

    // Reset wins over start in the same cycle.
    rst     = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    flush_reset();
    step();
    rst     = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/perm_controller.md
# perm_controller

Sequencing controller for the permutation datapath. On a `start` pulse it walks every line of every input file through a three-phase cycle: read the line, load the 25-bit register, write the permuted word. It drives the datapath's `read_file`, `write_reg`, `write_file`, `file_index` and `line_index` inputs, and reports `busy` and a one-cycle `done`. It sits beside the datapath inside the top-level design, which instantiates both.

## Interface
- `NUM_FILES`, default 1: number of files processed per run, 1..1024; file indices run 0..NUM_FILES-1.
- `NUM_LINES`, default 64: number of lines per file, 1..64; line indices run 0..NUM_LINES-1.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `busy`  out  1  high from the first READ cycle through the DONE cycle.
- `done`  out  1  one-cycle pulse when the run completes.
- `read_file`  out  1  datapath read strobe.
- `write_reg`  out  1  datapath register load.
- `write_file`  out  1  datapath write strobe.
- `file_index`  out  10  current file.
- `line_index`  out  6  current line.

## Operation
- FSM states: IDLE, READ, LOAD, WRITE, DONE.
- Outputs are Moore, decoded from the state register and the index counters only.
- IDLE:
  - `start`=1 → READ, with file=0 and line=0.
  - Otherwise stay in IDLE.
- READ: `read_file`=1 → LOAD.
- LOAD: `write_reg`=1 → WRITE.
- WRITE: `write_file`=1, then:
  - If line < NUM_LINES-1: line+1, → READ.
  - Else if file < NUM_FILES-1: line=0, file+1, → READ.
  - Else → DONE.
- DONE: `done`=1 → IDLE. Indices hold their last values until the next start clears them.
- Exactly one strobe is high in READ, LOAD and WRITE; no strobe is high in IDLE or DONE.
- `file_index` and `line_index` are stable across all three phases of a line.
- `start` while busy is ignored and not queued. `start` in the DONE cycle is also ignored.
- Index arithmetic is unsigned and never exceeds the bounds above; there is no wrap-around beyond the last file.

## Timing
- Reset values:
  - state = IDLE.
  - `busy`, `done`, `read_file`, `write_reg`, `write_file` = 0.
  - `file_index` = 0, `line_index` = 0.
- `rst` mid-run returns to IDLE on the next edge. There is no done pulse, and the strobes drop the same cycle.
- `rst` has priority over `start` in the same cycle.
- `start` high at edge k puts READ in cycle k+1.
- Per line: 3 cycles, so the write of line n follows its read by 2 cycles.
- Total run: `start` at edge 0 gives `done` in cycle 3·NUM_LINES·NUM_FILES+1. `busy` is high for 3·NUM_LINES·NUM_FILES+1 cycles.
- Back-to-back runs: `start` can be accepted in the cycle after DONE (IDLE), so the minimum gap is 1 idle cycle.
- Datapath contract: `read_file` data is valid at the following edge, which is when LOAD captures it. The permutation is combinational and valid during WRITE.

## Structure
- Shared package `perm_pkg`:
  - Widths FILE_IDX_W=10 and LINE_IDX_W=6.
  - State encoding constants S_IDLE..S_DONE.
  - Default NUM_FILES and NUM_LINES.
- One sub-module, `index_counter`: a nested line/file counter with inputs `clr`, `inc` and bound parameters.
  - Outputs `line`, `file`, `last_line`, `last`.
  - The FSM uses `last` to select the WRITE→DONE transition.
- Integration top (`perm_top`) instantiates `perm_controller` and `datapath`; it is a separate file.

## Test plan
- Reset then idle: hold `rst` 2 cycles with `start`=0 for 10 cycles → all outputs 0, state IDLE.
- Single run, NUM_FILES=1, NUM_LINES=4:
  - `start` pulse at cycle 0 → strobe sequence R,L,W ×4 on lines 0..3, file 0.
  - `done` in cycle 13; `busy` high cycles 1..13.
- Multi-file, NUM_FILES=3, NUM_LINES=2:
  - `file_index` 0,0,1,1,2,2 per line; `line_index` 0,1 repeating.
  - `done` in cycle 19.
- Start while busy: second `start` at cycle 5 in the single-run case → ignored; `done` still at cycle 13; no second run.
- Reset mid-run: `rst` at cycle 7 → IDLE at cycle 8, no `done`. A new `start` at cycle 10 restarts at file 0, line 0.
- Back-to-back runs: `start` at cycle 0 and again at cycle 14 (IDLE) → second run's READ in cycle 15, with indices reset to 0.
